// File: rtl/seq_stage_ctrl.sv
// One-hot stage sequencer for the 16-bit RISC core: stall hold, branch flush,
// memory wait, graceful halt, retire counter. Optional timeout: SEQ_STAGE_CTRL_TIMEOUT_EN.
module seq_stage_ctrl #(
    parameter int STAGES    = 6,
    parameter int MEM_STAGE = 5,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              halt_req,
    input  logic              mem_ready,
    output logic [STAGES-1:0] en,
    output logic              mem_req,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              halted,
    output logic              err,
    output logic [1:0]        dbg_state
);

    if (STAGES < 2 || STAGES > 8 || MEM_STAGE < 0 || MEM_STAGE >= STAGES ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("seq_stage_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [STAGES-1:0] FETCH = {{(STAGES-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nx;
    logic [STAGES-1:0] en_nx;
    logic [CNT_W-1:0]  retire_nx;
    logic              halted_nx;

`ifdef SEQ_STAGE_CTRL_TIMEOUT_EN
    localparam logic [7:0] TO = TIMEOUT[7:0];
    logic [7:0] tcnt;
    logic [7:0] tcnt_nx;
    logic       err_r;
    logic       err_nx;
`endif

    // Handshake: mem_req is high while the memory stage is enabled in RUN and no
    // flush is abandoning it; the stage completes on an edge with mem_ready=1 and stall=0.
    assign mem_req   = en[MEM_STAGE] & (state == S_RUN) & ~flush;
    assign dbg_state = state;

    always_comb begin
        state_nx  = state;
        en_nx     = en;
        retire_nx = retire_cnt;
        halted_nx = halted;
`ifdef SEQ_STAGE_CTRL_TIMEOUT_EN
        tcnt_nx   = tcnt;
        err_nx    = err_r;
`endif
        case (state)
            S_IDLE: begin
                state_nx = S_RUN;
                en_nx    = FETCH;
            end
            S_RUN: begin
                if (flush) begin
                    en_nx = FETCH;
`ifdef SEQ_STAGE_CTRL_TIMEOUT_EN
                    tcnt_nx = 8'd0;
`endif
                end else if (stall) begin
                    en_nx = en;
                end else if (en[MEM_STAGE] && !mem_ready) begin
`ifdef SEQ_STAGE_CTRL_TIMEOUT_EN
                    tcnt_nx = tcnt + 8'd1;
                    if (tcnt + 8'd1 == TO) begin
                        state_nx = S_ERR;
                        en_nx    = '0;
                        err_nx   = 1'b1;
                    end
`endif
                end else begin
`ifdef SEQ_STAGE_CTRL_TIMEOUT_EN
                    tcnt_nx = 8'd0;
`endif
                    if (en[STAGES-1]) begin
                        // Instruction boundary: retire, then either restart or park.
                        retire_nx = retire_cnt + CNT_W'(1);
                        if (halt_req) begin
                            state_nx  = S_HALT;
                            en_nx     = '0;
                            halted_nx = 1'b1;
                        end else begin
                            en_nx = FETCH;
                        end
                    end else begin
                        en_nx = en << 1;
                    end
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_nx  = S_RUN;
                    en_nx     = FETCH;
                    halted_nx = 1'b0;
                end
            end
            S_ERR: begin
                en_nx = '0;
            end
            default: begin
                state_nx = S_IDLE;
                en_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            en         <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nx;
            en         <= en_nx;
            retire_cnt <= retire_nx;
            halted     <= halted_nx;
        end
    end

`ifdef SEQ_STAGE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt  <= 8'd0;
            err_r <= 1'b0;
        end else begin
            tcnt  <= tcnt_nx;
            err_r <= err_nx;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Parametrised stage sequencer for the 16-bit RISC core, successor to the fixed six-enable control unit. It drives one-hot stage enables (fetch, decode, reg-read, ALU, reg-write, memory by default) with stall hold, branch flush, a ready/request handshake on the memory stage, graceful halt and an instruction-retire counter. It sits between the top-level clock/reset and the enable inputs of the fetch, decoder, register file, ALU and RAM blocks.

## Interface
- `STAGES`, 6, number of stages, legal range 2..8; `en[0]` is fetch.
- `MEM_STAGE`, 5, index of the stage that waits for memory, 0..STAGES-1.
- `CNT_W`, 16, width of the retire counter.
- `TIMEOUT`, 15, maximum memory-wait cycles before error, 1..255.

Ports:
- `clk` in 1: the only clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `stall` in 1: hold the current stage.
- `flush` in 1: abort the current instruction and restart at fetch (branch taken).
- `halt_req` in 1: stop at the next instruction boundary.
- `mem_ready` in 1: memory completion, sampled while `mem_req`=1.
- `en` out STAGES: one-hot stage enables, registered.
- `mem_req` out 1: memory request, combinational.
- `retire_cnt` out CNT_W: completed instructions.
- `halted` out 1: high in the HALT state.
- `err` out 1: sticky memory-timeout error.

## Operation
- States: IDLE, RUN, HALT, ERR.
- Reset (`reset`=0): state IDLE; `en`=0, `retire_cnt`=0, `err`=0, `halted`=0, timeout counter=0.
- IDLE → RUN on the first edge with reset released; `en` becomes `1<<0`.
- RUN, next-`en` priority: flush > stall > memory wait > advance.
  - flush=1: `en`=`1<<0`, no retire, timeout counter cleared. An outstanding memory request is abandoned.
  - stall=1: `en` held; the timeout counter is also held.
  - In MEM_STAGE with `mem_ready`=0: `en` held and the timeout counter increments.
  - Advance: `en` rotates left by one.
  - Leaving stage STAGES-1 completes an instruction. `retire_cnt` increments, wrapping modulo 2^CNT_W, and `en` returns to `1<<0`.
- `mem_req` = `en[MEM_STAGE]` & (state==RUN) & ~flush.
- The memory stage advances on the edge where `mem_ready`=1 and stall=0. The timeout counter clears on that edge.
- halt_req is sampled only at the instruction boundary (leaving stage STAGES-1).
  - If 1: the retire still counts, state becomes HALT, `en`=0, `halted`=1.
  - HALT → RUN on the first edge with halt_req=0; `en`=`1<<0`, `halted`=0.
  - flush and stall are ignored in HALT.
- ERR: entered when the timeout counter reaches TIMEOUT while waiting. `en`=0, `err`=1, `mem_req`=0. The only exit is reset.
- flush in the same cycle as `mem_ready`: flush wins and the instruction is not retired.
- Asserting reset mid-instruction clears everything immediately; there is no partial retire.

## Timing
- All outputs except `mem_req` are registered. `mem_req` is combinational from `en` and state.
- With no stall or wait, one instruction takes exactly STAGES cycles, and `retire_cnt` updates on the edge where `en` returns to stage 0.
- flush takes effect on the next edge: fetch is asserted one cycle after the flush cycle.
- Memory wait adds one cycle per `mem_ready`=0 cycle.
- Error timing:
  - Counting starts on the first cycle spent waiting in the memory stage.
  - On the edge where the counter would reach TIMEOUT, `err` rises and `en` becomes 0 on that same edge.
  - TIMEOUT=15 therefore gives 15 waiting cycles, then ERR.
- Reset is asynchronous on assertion. Release is taken on the next rising edge (IDLE lasts at least one cycle).

## Configuration
- `SEQ_STAGE_CTRL_TIMEOUT_EN` defined: the timeout counter, the ERR state and `err` are implemented as described.
- `SEQ_STAGE_CTRL_TIMEOUT_EN` undefined:
  - No counter and no ERR state.
  - The memory stage waits indefinitely for `mem_ready`.
  - `err` is tied to 0.
  - The TIMEOUT parameter is ignored.

## Test plan
- Reset low then released, defaults, `mem_ready`=1 constant: `en` sequence is 000001, 000010, …, 100000, 000001. `retire_cnt`=1 after 6 cycles, 10 after 60 cycles.
- stall high for 3 cycles while `en`=000100: `en` stays 000100 for 4 cycles total, then 001000. Retire is delayed by 3 cycles.
- flush pulse while `en`=001000: next `en`=000001 and `retire_cnt` unchanged. Flush together with `mem_ready` in stage 5: no retire.
- halt_req=1 through stage 5: `retire_cnt` increments, `halted`=1 and `en`=0. Dropping halt_req makes `en`=000001 on the next edge.
- With TIMEOUT_EN, `mem_ready`=0 held in stage 5: `mem_req`=1 for 15 cycles, then `err`=1, `en`=0, `mem_req`=0 until reset. Without TIMEOUT_EN: waits forever, `err`=0.
- CNT_W=4, run 17 instructions: `retire_cnt` wraps to 1. Reset asserted mid-stage-3: all outputs 0 asynchronously.
